// File: rtl/reg_file_arbiter.sv
// Shares one reg_file command port between writeback (rq0) and memory stage (rq1).
// Define REGARB_WB_PRIORITY_EN to make rq0 win every tie instead of round-robin.
module reg_file_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_CMD_WIDTH  = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               rq0_reg,
  input  logic [DATA_WIDTH-1:0]    rq0_data,
  input  logic [REG_CMD_WIDTH-1:0] rq0_cmd,
  input  logic                     rq0_valid,
  input  logic                     rq0_res_ready,
  output logic [DATA_WIDTH-1:0]    rq0_resp,
  output logic                     rq0_res_valid,
  output logic                     rq0_err,
  output logic                     rq0_ready,
  input  logic [3:0]               rq1_reg,
  input  logic [DATA_WIDTH-1:0]    rq1_data,
  input  logic [REG_CMD_WIDTH-1:0] rq1_cmd,
  input  logic                     rq1_valid,
  input  logic                     rq1_res_ready,
  output logic [DATA_WIDTH-1:0]    rq1_resp,
  output logic                     rq1_res_valid,
  output logic                     rq1_err,
  output logic                     rq1_ready,
  output logic [3:0]               rf_reg,
  output logic [DATA_WIDTH-1:0]    rf_data,
  output logic [REG_CMD_WIDTH-1:0] rf_cmd,
  output logic                     rf_valid,
  output logic                     rf_res_ready,
  input  logic [DATA_WIDTH-1:0]    rf_resp,
  input  logic                     rf_res_valid,
  input  logic                     rf_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT_CYCLES);

  state_t                   state_q, state_d;
  logic                     win_q, win_d;
  logic                     last_q, last_d;
  logic                     err_q, err_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [3:0]               reg_q, reg_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [REG_CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0]    resp_q, resp_d;
  logic                     pick;
  logic                     any_req;
  logic                     win_taken;

  assign any_req = rq0_valid | rq1_valid;
  assign win_taken = win_q ? rq1_res_ready : rq0_res_ready;

`ifdef REGARB_WB_PRIORITY_EN
  assign pick = ~rq0_valid;
`else
  // On a tie the requester that did not win last time goes next.
  assign pick = (rq0_valid & rq1_valid) ? ~last_q : ~rq0_valid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      cmd_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: begin
        if (any_req && rf_ready) begin
          win_d   = pick;
          reg_d   = pick ? rq1_reg : rq0_reg;
          data_d  = pick ? rq1_data : rq0_data;
          cmd_d   = pick ? rq1_cmd : rq0_cmd;
          cnt_d   = TO_LOAD;
          err_d   = 1'b0;
          resp_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q - 8'd1;
        if (rf_res_valid) begin
          resp_d  = rf_resp;
          cnt_d   = '0;
          state_d = RESP;
        end else if (cnt_q == 8'd1) begin
          resp_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (win_taken) begin
          last_d  = win_q;
          err_d   = 1'b0;
          resp_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic issue;
  logic busy;
  logic resp_st;

  assign issue   = (state_q == ISSUE);
  assign busy    = (state_q != IDLE);
  assign resp_st = (state_q == RESP);

  assign rf_valid     = issue;
  assign rf_res_ready = issue;
  assign rf_reg       = issue ? reg_q : '0;
  assign rf_data      = issue ? data_q : '0;
  assign rf_cmd       = issue ? cmd_q : '0;

  assign rq0_ready     = busy & ~win_q;
  assign rq1_ready     = busy & win_q;
  assign rq0_res_valid = resp_st & ~win_q;
  assign rq1_res_valid = resp_st & win_q;
  assign rq0_err       = rq0_res_valid & err_q;
  assign rq1_err       = rq1_res_valid & err_q;
  assign rq0_resp      = rq0_res_valid ? resp_q : '0;
  assign rq1_resp      = rq1_res_valid ? resp_q : '0;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Randomized transaction-level bench for reg_file_arbiter.
// Model tracks pending requests and last winner; reg_file is emulated here.
module tb_reg_file_arbiter;

  localparam int DW = 32;
  localparam int CW = 2;
  localparam int TO = 4;
  localparam logic [CW-1:0] CMD_WRITE = 2'd1;
`ifdef REGARB_WB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    q_reg [2];
  logic [DW-1:0] q_data [2];
  logic [CW-1:0] q_cmd [2];
  logic          q_valid [2];
  logic          q_res_ready [2];
  logic [DW-1:0] o_resp [2];
  logic          o_res_valid [2];
  logic          o_err [2];
  logic          o_ready [2];
  logic [3:0]    rf_reg;
  logic [DW-1:0] rf_data;
  logic [CW-1:0] rf_cmd;
  logic          rf_valid;
  logic          rf_res_ready;
  logic [DW-1:0] rf_resp;
  logic          rf_res_valid;
  logic          rf_ready;

  int total = 0;
  int bad = 0;
  int last_w = 1;
  bit pend [2];

  always #5 clk = ~clk;

  reg_file_arbiter #(
    .DATA_WIDTH(DW),
    .REG_CMD_WIDTH(CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rq0_reg(q_reg[0]),
    .rq0_data(q_data[0]),
    .rq0_cmd(q_cmd[0]),
    .rq0_valid(q_valid[0]),
    .rq0_res_ready(q_res_ready[0]),
    .rq0_resp(o_resp[0]),
    .rq0_res_valid(o_res_valid[0]),
    .rq0_err(o_err[0]),
    .rq0_ready(o_ready[0]),
    .rq1_reg(q_reg[1]),
    .rq1_data(q_data[1]),
    .rq1_cmd(q_cmd[1]),
    .rq1_valid(q_valid[1]),
    .rq1_res_ready(q_res_ready[1]),
    .rq1_resp(o_resp[1]),
    .rq1_res_valid(o_res_valid[1]),
    .rq1_err(o_err[1]),
    .rq1_ready(o_ready[1]),
    .rf_reg(rf_reg),
    .rf_data(rf_data),
    .rf_cmd(rf_cmd),
    .rf_valid(rf_valid),
    .rf_res_ready(rf_res_ready),
    .rf_resp(rf_resp),
    .rf_res_valid(rf_res_valid),
    .rf_ready(rf_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i);
    q_reg[i]   = 4'($urandom);
    q_data[i]  = $urandom;
    q_cmd[i]   = CW'($urandom);
    q_valid[i] = 1'b1;
    pend[i]    = 1'b1;
  endtask

  function automatic logic [7:0] all_outs();
    return {rf_valid, rf_res_ready, o_ready[0], o_ready[1],
            o_res_valid[0], o_res_valid[1], o_err[0], o_err[1]};
  endfunction

  task automatic run_txn(input bit both);
    int w, lat, stall, cnt, blk;
    bit tmo;
    bit chk_data;
    logic [DW-1:0] val;
    for (int i = 0; i < 2; i++)
      if (!pend[i] && (both || $urandom_range(1, 0) == 1)) new_req(i);
    if (!pend[0] && !pend[1]) new_req(int'($urandom_range(1, 0)));
    if (pend[0] && pend[1]) w = PRIO ? 0 : 1 - last_w;
    else w = pend[0] ? 0 : 1;
    blk = $urandom_range(2, 0);
    rf_ready = 1'b0;
    for (int c = 0; c < blk; c++) begin
      tick();
      chk("blocked", {63'd0, rf_valid}, 64'd0);
    end
    rf_ready = 1'b1;
    tick();
    chk("grant_valid", {63'd0, rf_valid}, 64'd1);
    chk("grant_win", {62'd0, o_ready[1], o_ready[0]}, (w == 1) ? 64'd2 : 64'd1);
    chk("rf_fields", {30'd0, rf_reg, rf_data}, {30'd0, q_reg[w], q_data[w]});
    chk("rf_cmd", 64'(rf_cmd), 64'(q_cmd[w]));
    if ($urandom_range(3, 0) == 0) q_valid[w] = 1'b0;
    tmo = ($urandom_range(3, 0) == 0);
    if (!tmo) begin
      lat = $urandom_range(TO, 1);
      for (int c = 2; c <= lat; c++) begin
        tick();
        chk("issue_hold", {63'd0, rf_valid}, 64'd1);
      end
      val = $urandom;
      rf_resp = val;
      rf_res_valid = 1'b1;
      tick();
      rf_res_valid = 1'b0;
      rf_resp = $urandom;
    end else begin
      cnt = 0;
      while (rf_valid && cnt < TO + 4) begin
        cnt++;
        tick();
      end
      chk("timeout_len", 64'(cnt), 64'(TO));
      val = '0;
      rf_resp = $urandom;
      rf_res_valid = 1'b1;
      tick();
      rf_res_valid = 1'b0;
    end
    chk_data = tmo || (q_cmd[w] != CMD_WRITE);
    stall = $urandom_range(3, 0);
    for (int c = 0; c <= stall; c++) begin
      chk("res_valid", {62'd0, o_res_valid[1], o_res_valid[0]},
          (w == 1) ? 64'd2 : 64'd1);
      chk("res_err", {63'd0, o_err[w]}, {63'd0, tmo});
      if (chk_data) chk("res_data", 64'(o_resp[w]), 64'(val));
      if (c < stall) tick();
    end
    q_res_ready[w] = 1'b1;
    tick();
    q_res_ready[w] = 1'b0;
    chk("accept_idle", 64'(all_outs()), 64'd0);
    q_valid[w] = 1'b0;
    pend[w] = 1'b0;
    last_w = w;
  endtask

  task automatic reset_mid(input bit in_resp);
    for (int i = 0; i < 2; i++) if (!pend[i]) new_req(i);
    rf_ready = 1'b1;
    tick();
    if (in_resp) begin
      rf_resp = $urandom;
      rf_res_valid = 1'b1;
      tick();
      rf_res_valid = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    chk(in_resp ? "rst_resp" : "rst_issue", 64'(all_outs()), 64'd0);
    chk("rst_data", {o_resp[1], o_resp[0]}, 64'd0);
    tick();
    reset = 1'b0;
    last_w = 1;
  endtask

  initial begin
    reset = 1'b1;
    rf_ready = 1'b1;
    rf_res_valid = 1'b0;
    rf_resp = '0;
    for (int i = 0; i < 2; i++) begin
      q_reg[i] = '0;
      q_data[i] = '0;
      q_cmd[i] = '0;
      q_valid[i] = 1'b0;
      q_res_ready[i] = 1'b0;
      pend[i] = 1'b0;
    end
    tick();
    tick();
    chk("reset_outs", 64'(all_outs()), 64'd0);
    chk("reset_rf", {30'd0, rf_reg, rf_data}, 64'd0);
    reset = 1'b0;
    tick();
    for (int t = 0; t < 6; t++) run_txn(1'b1);
    for (int t = 0; t < 40; t++) run_txn(1'b0);
    reset_mid(1'b0);
    run_txn(1'b1);
    reset_mid(1'b1);
    run_txn(1'b1);
    for (int t = 0; t < 10; t++) run_txn(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
